hold_timer: RTL and testbench
=============================

# hold_timer

Parametrised one-shot hold timer: a rising edge on a level input (push-button) starts a timed window of `duration` ticks, with one tick every `PRESCALE` clock cycles. It asserts `active` for exactly that window, then pulses `done`. It is the generalised successor of the fixed-length display-hold timer. It sits between the key input and the display/number-generator control logic. It adds a runtime-programmable length, a prescaler, retrigger mode, abort, and status outputs.

## Interface
- `PRESCALE`, default 50_000_000: clock cycles per tick (≥1); 1 s at 50 MHz.
- `HOLD_W`, default 8: width of `duration`/`remaining`.
- `RETRIGGER`, default 0: 0 = presses during a run are ignored; 1 = a press reloads the window.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `key` in 1: raw button level, asynchronous to `clk`.
- `abort` in 1: synchronous cancel, level.
- `duration` in HOLD_W: window length in ticks; sampled only on a trigger.
- `active` out 1: timing window in progress.
- `done` out 1: one-cycle pulse at normal window end.
- `tick` out 1: one-cycle pulse on each prescaler wrap during a run.
- `remaining` out HOLD_W: ticks left; 0 when idle.

## Operation
- **Key path:** `key` → 2-flop synchroniser → delay flop. `rise = s2 & ~d`. Holding `key` high produces exactly one trigger.
- **States:** IDLE, RUN.
- **IDLE → RUN** on `rise` with `duration != 0`:
  - load `remaining = duration`;
  - clear the prescaler;
  - `active = 1`.
- **Zero duration:** `rise` with `duration == 0` is ignored. No `active`, no `done`.
- **Prescaler:** in RUN it counts 0..PRESCALE-1. On wrap, `tick` = 1 and `remaining` decrements.
- **RUN → IDLE (normal end):** on the wrap where `remaining == 1`:
  - `remaining = 0`;
  - `active = 0`;
  - `done = 1` for one cycle;
  - `tick` also pulses.
- **Retrigger:** `rise` in RUN with RETRIGGER=1 reloads `remaining = duration` and clears the prescaler. If `duration == 0`, the press is ignored. With RETRIGGER=0, presses in RUN are dropped, not queued.
- **Priority, per cycle:** reset > abort > `rise` (reload/start) > tick/decrement.
- **Abort:** in RUN → IDLE next edge, `active = 0`, `remaining = 0`, prescaler cleared, no `done`, no `tick`. In IDLE, abort suppresses a coincident `rise`.
- **`rise` coincident with the final wrap:**
  - RETRIGGER=1: reload wins; no `done`, no `tick`.
  - RETRIGGER=0: the window ends normally with `done`.
- **Prescaler width:** `$clog2(PRESCALE)`, minimum 1. With PRESCALE=1, every RUN cycle is a wrap.
- **Reset:** all outputs, state, prescaler and synchroniser flops = 0, state = IDLE, immediately and with no clock required.

## Timing
- `key` sampled high at edge N → `active` high after edge N+2.
- `active` high for exactly `duration × PRESCALE` cycles.
- `done` is high in the first cycle `active` is low.
- All outputs are registered; no combinational input→output paths.
- `tick`, `remaining` decrement and `done` change on the same edge.
- `abort` asserted before edge M → `active` low after edge M.

## Structure
- **Shared package `timer_pkg`:**
  - state encoding localparams `ST_IDLE = 1'b0`, `ST_RUN = 1'b1`;
  - default `PRESCALE_1S = 50_000_000`.
- **Sub-module `key_edge_sync`:** synchroniser, delay flop and rising-edge pulse. It is reused by other button-driven blocks.
- **Top:** FSM, prescaler and remaining counter.

## Test plan
Bench parameters: PRESCALE=4, HOLD_W=8.
- **Basic window:** `key` high at edge 0, held, `duration = 3` →
  - `active` rises after edge 2 and stays high 12 cycles;
  - `tick` ×3;
  - `remaining` 3→2→1→0;
  - one `done` pulse;
  - no second trigger while `key` is held.
- **RETRIGGER=1:** second press 6 cycles into a `duration = 3` run → `remaining` reloads to 3 and `active` totals 18 cycles, with a single `done`. Second press coinciding with the final wrap → no `done`, `active` continues.
- **RETRIGGER=0:** same stimulus as the RETRIGGER=1 case → `active` 12 cycles, press dropped, no second window.
- **Abort mid-run, `duration = 5`:**
  - abort at cycle 7 → `active` and `remaining` 0 next edge, no `done`;
  - subsequent press starts a fresh 20-cycle window.
- **Zero duration:** `duration = 0` press → `active` and `done` stay 0.
- **Reset mid-run:** `rst_n` low mid-run, asserted between clock edges → all outputs 0 immediately and the FSM in IDLE. After release, the next press behaves as in the basic window scenario.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for button-driven timer blocks.
package timer_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // One second at a 50 MHz system clock.
   localparam int unsigned PRESCALE_1S = 50_000_000;

endpackage

// File: rtl/key_edge_sync.sv
// Synchronises an asynchronous button level and flags its rising edge for one cycle.
module key_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic rise_c
);

   logic s1;
   logic s2;
   logic d;

   // Two-flop synchroniser followed by a delay flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         d  <= 1'b0;
      end else begin
         s1 <= key;
         s2 <= s1;
         d  <= s2;
      end
   end

   assign rise_c = s2 & ~d;

endmodule

// File: rtl/hold_timer.sv
// One-shot hold timer: a key press opens a window of `duration` prescaled ticks.
module hold_timer
   import timer_pkg::*;
#(
   parameter int unsigned PRESCALE  = PRESCALE_1S,
   parameter int unsigned HOLD_W    = 8,
   parameter bit          RETRIGGER = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key,
   input  logic              abort,
   input  logic [HOLD_W-1:0] duration,
   output logic              active,
   output logic              done,
   output logic              tick,
   output logic [HOLD_W-1:0] remaining
);

   localparam int unsigned        CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(PRESCALE - 1);

   logic              rise_c;
   logic              load_c;
   logic              wrap_c;
   logic [0:0]        state_q;
   logic [0:0]        state_nx;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_nx;
   logic [HOLD_W-1:0] rem_nx;
   logic              active_nx;
   logic              done_nx;
   logic              tick_nx;

   key_edge_sync u_key_edge_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .key    (key),
      .rise_c (rise_c)
   );

   // A press with zero length never starts or reloads a window.
   assign load_c = rise_c & (duration != '0);
   assign wrap_c = (cnt_q == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         remaining <= '0;
         active    <= 1'b0;
         done      <= 1'b0;
         tick      <= 1'b0;
      end else begin
         state_q   <= state_nx;
         cnt_q     <= cnt_nx;
         remaining <= rem_nx;
         active    <= active_nx;
         done      <= done_nx;
         tick      <= tick_nx;
      end
   end

   // Per-cycle priority: abort, then press (start/reload), then tick.
   always_comb begin
      state_nx  = state_q;
      cnt_nx    = cnt_q;
      rem_nx    = remaining;
      active_nx = active;
      done_nx   = 1'b0;
      tick_nx   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!abort && load_c) begin
               state_nx  = ST_RUN;
               rem_nx    = duration;
               cnt_nx    = '0;
               active_nx = 1'b1;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_nx  = ST_IDLE;
               rem_nx    = '0;
               cnt_nx    = '0;
               active_nx = 1'b0;
            end else if (RETRIGGER && load_c) begin
               rem_nx = duration;
               cnt_nx = '0;
            end else if (wrap_c) begin
               tick_nx = 1'b1;
               cnt_nx  = '0;
               if (remaining == HOLD_W'(1)) begin
                  state_nx  = ST_IDLE;
                  rem_nx    = '0;
                  active_nx = 1'b0;
                  done_nx   = 1'b1;
               end else begin
                  rem_nx = remaining - HOLD_W'(1);
               end
            end else begin
               cnt_nx = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_nx  = ST_IDLE;
            rem_nx    = '0;
            cnt_nx    = '0;
            active_nx = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_hold_timer.sv
// Bench for hold_timer: two instances (RETRIGGER 0 and 1) share one stimulus stream.
module tb_hold_timer;
   import timer_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       key = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] duration = 8'd0;
   logic [1:0] active;
   logic [1:0] done;
   logic [1:0] tick;
   logic [7:0] remaining [2];

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      int          cyc;
      int          dut;
      string       tag;
      logic [10:0] v;
   } exp_t;

   exp_t sbq[$];
   int   act_cnt [2] = '{0, 0};
   int   done_cnt [2] = '{0, 0};
   int   tick_cnt [2] = '{0, 0};
   int   s_act [2];
   int   s_done [2];
   int   s_tick [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   hold_timer #(.PRESCALE(4), .HOLD_W(8), .RETRIGGER(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .key(key), .abort(abort), .duration(duration),
      .active(active[0]), .done(done[0]), .tick(tick[0]), .remaining(remaining[0])
   );

   hold_timer #(.PRESCALE(4), .HOLD_W(8), .RETRIGGER(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .key(key), .abort(abort), .duration(duration),
      .active(active[1]), .done(done[1]), .tick(tick[1]), .remaining(remaining[1])
   );

   // Scoreboard consumer: pops every expectation due at this cycle.
   always @(negedge clk) begin
      exp_t        e;
      logic [10:0] obs;
      for (int i = 0; i < 2; i++) begin
         act_cnt[i]  += int'(active[i]);
         done_cnt[i] += int'(done[i]);
         tick_cnt[i] += int'(tick[i]);
      end
      while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
         e   = sbq.pop_front();
         obs = {active[e.dut], done[e.dut], tick[e.dut], remaining[e.dut]};
         checks++;
         assert (obs === e.v && e.cyc == cyc) else begin
            errors++;
            $error("FAIL %s dut%0d @%0d: observed a/d/t/rem=%b/%b/%b/%0d expected %b/%b/%b/%0d (due @%0d)",
                   e.tag, e.dut, cyc, obs[10], obs[9], obs[8], obs[7:0],
                   e.v[10], e.v[9], e.v[8], e.v[7:0], e.cyc);
         end
      end
   end

   task automatic exp_at(input int c, input int dut, input string tag,
                         input logic a, input logic d, input logic t, input logic [7:0] r);
      exp_t e;
      e.cyc = c;
      e.dut = dut;
      e.tag = tag;
      e.v   = {a, d, t, r};
      sbq.push_back(e);
   endtask

   task automatic exp_both(input int c, input string tag,
                           input logic a, input logic d, input logic t, input logic [7:0] r);
      exp_at(c, 0, tag, a, d, t, r);
      exp_at(c, 1, tag, a, d, t, r);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic snap();
      for (int i = 0; i < 2; i++) begin
         s_act[i]  = act_cnt[i];
         s_done[i] = done_cnt[i];
         s_tick[i] = tick_cnt[i];
      end
   endtask

   task automatic chk_delta(input string tag, input int dut, input int a, input int d, input int t);
      chk({tag, "_active_cycles"}, 32'(act_cnt[dut] - s_act[dut]), 32'(a));
      chk({tag, "_done_pulses"}, 32'(done_cnt[dut] - s_done[dut]), 32'(d));
      chk({tag, "_ticks"}, 32'(tick_cnt[dut] - s_tick[dut]), 32'(t));
   endtask

   task automatic chk_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk({tag, "_active"}, 32'(active[i]), 32'd0);
         chk({tag, "_done"}, 32'(done[i]), 32'd0);
         chk({tag, "_tick"}, 32'(tick[i]), 32'd0);
         chk({tag, "_remaining"}, 32'(remaining[i]), 32'd0);
      end
      chk({tag, "_state0"}, 32'(u_dut0.state_q), 32'(ST_IDLE));
      chk({tag, "_state1"}, 32'(u_dut1.state_q), 32'(ST_IDLE));
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst_n = 1'b0;
      #1 chk_zero("reset");
      wait_cyc(2);
      rst_n = 1'b1;

      // Basic window, key held long: single trigger.
      wait_cyc(5);
      snap();
      key = 1'b1; duration = 8'd3;
      exp_both(7,  "basic_pre",   1'b0, 1'b0, 1'b0, 8'd0);
      exp_both(8,  "basic_start", 1'b1, 1'b0, 1'b0, 8'd3);
      exp_both(11, "basic_c3",    1'b1, 1'b0, 1'b0, 8'd3);
      exp_both(12, "basic_tick1", 1'b1, 1'b0, 1'b1, 8'd2);
      exp_both(13, "basic_c5",    1'b1, 1'b0, 1'b0, 8'd2);
      exp_both(16, "basic_tick2", 1'b1, 1'b0, 1'b1, 8'd1);
      exp_both(19, "basic_last",  1'b1, 1'b0, 1'b0, 8'd1);
      exp_both(20, "basic_done",  1'b0, 1'b1, 1'b1, 8'd0);
      exp_both(21, "basic_after", 1'b0, 1'b0, 1'b0, 8'd0);
      exp_both(30, "basic_held",  1'b0, 1'b0, 1'b0, 8'd0);
      wait_cyc(30);
      key = 1'b0;
      wait_cyc(31);
      for (int i = 0; i < 2; i++) chk_delta("basic", i, 12, 1, 3);

      // Second press six cycles into the run.
      wait_cyc(40);
      snap();
      key = 1'b1; duration = 8'd3;
      exp_both(43, "rt_start", 1'b1, 1'b0, 1'b0, 8'd3);
      exp_both(47, "rt_tick1", 1'b1, 1'b0, 1'b1, 8'd2);
      exp_at(49, 0, "rt_drop",   1'b1, 1'b0, 1'b0, 8'd2);
      exp_at(49, 1, "rt_reload", 1'b1, 1'b0, 1'b0, 8'd3);
      exp_at(51, 0, "rt_tick2",  1'b1, 1'b0, 1'b1, 8'd1);
      exp_at(51, 1, "rt_cnt",    1'b1, 1'b0, 1'b0, 8'd3);
      exp_at(53, 0, "rt_last",   1'b1, 1'b0, 1'b0, 8'd1);
      exp_at(53, 1, "rt_tick2",  1'b1, 1'b0, 1'b1, 8'd2);
      exp_at(55, 0, "rt_done",   1'b0, 1'b1, 1'b1, 8'd0);
      exp_at(55, 1, "rt_run",    1'b1, 1'b0, 1'b0, 8'd2);
      exp_at(56, 0, "rt_idle",   1'b0, 1'b0, 1'b0, 8'd0);
      exp_at(61, 0, "rt_nowin",  1'b0, 1'b0, 1'b0, 8'd0);
      exp_at(61, 1, "rt_done",   1'b0, 1'b1, 1'b1, 8'd0);
      exp_at(62, 1, "rt_idle",   1'b0, 1'b0, 1'b0, 8'd0);
      wait_cyc(42); key = 1'b0;
      wait_cyc(46); key = 1'b1;
      wait_cyc(48); key = 1'b0;
      wait_cyc(65);
      chk_delta("rt_mid0", 0, 12, 1, 3);
      chk_delta("rt_mid1", 1, 18, 1, 4);

      // Second press landing on the final wrap.
      wait_cyc(70);
      snap();
      key = 1'b1; duration = 8'd3;
      exp_both(73, "rtw_start", 1'b1, 1'b0, 1'b0, 8'd3);
      exp_both(81, "rtw_tick2", 1'b1, 1'b0, 1'b1, 8'd1);
      exp_both(84, "rtw_pre",   1'b1, 1'b0, 1'b0, 8'd1);
      exp_at(85, 0, "rtw_done",   1'b0, 1'b1, 1'b1, 8'd0);
      exp_at(85, 1, "rtw_reload", 1'b1, 1'b0, 1'b0, 8'd3);
      exp_at(86, 0, "rtw_idle",   1'b0, 1'b0, 1'b0, 8'd0);
      exp_at(86, 1, "rtw_run",    1'b1, 1'b0, 1'b0, 8'd3);
      exp_at(89, 1, "rtw_tick",   1'b1, 1'b0, 1'b1, 8'd2);
      exp_at(90, 0, "rtw_noq",    1'b0, 1'b0, 1'b0, 8'd0);
      exp_at(97, 1, "rtw_done",   1'b0, 1'b1, 1'b1, 8'd0);
      exp_at(98, 1, "rtw_idle",   1'b0, 1'b0, 1'b0, 8'd0);
      wait_cyc(72); key = 1'b0;
      wait_cyc(82); key = 1'b1;
      wait_cyc(84); key = 1'b0;
      wait_cyc(100);
      chk_delta("rtw0", 0, 12, 1, 3);
      chk_delta("rtw1", 1, 24, 1, 5);

      // Abort seven cycles into a five-tick run, then a fresh window.
      wait_cyc(103);
      snap();
      wait_cyc(105);
      key = 1'b1; duration = 8'd5;
      exp_both(108, "ab_start", 1'b1, 1'b0, 1'b0, 8'd5);
      exp_both(112, "ab_tick",  1'b1, 1'b0, 1'b1, 8'd4);
      exp_both(114, "ab_pre",   1'b1, 1'b0, 1'b0, 8'd4);
      exp_both(115, "ab_stop",  1'b0, 1'b0, 1'b0, 8'd0);
      exp_both(116, "ab_after", 1'b0, 1'b0, 1'b0, 8'd0);
      wait_cyc(107); key = 1'b0;
      wait_cyc(114); abort = 1'b1;
      wait_cyc(115); abort = 1'b0;
      wait_cyc(118);
      for (int i = 0; i < 2; i++) chk_delta("abort", i, 7, 0, 1);
      snap();
      wait_cyc(120);
      key = 1'b1; duration = 8'd5;
      exp_both(123, "fresh_start", 1'b1, 1'b0, 1'b0, 8'd5);
      exp_both(127, "fresh_tick",  1'b1, 1'b0, 1'b1, 8'd4);
      exp_both(142, "fresh_last",  1'b1, 1'b0, 1'b0, 8'd1);
      exp_both(143, "fresh_done",  1'b0, 1'b1, 1'b1, 8'd0);
      exp_both(144, "fresh_idle",  1'b0, 1'b0, 1'b0, 8'd0);
      wait_cyc(122); key = 1'b0;
      wait_cyc(146);
      for (int i = 0; i < 2; i++) chk_delta("fresh", i, 20, 1, 5);

      // Abort in IDLE swallows a coincident press.
      snap();
      wait_cyc(148);
      key = 1'b1; duration = 8'd3;
      exp_both(151, "idle_abort",  1'b0, 1'b0, 1'b0, 8'd0);
      exp_both(152, "idle_abort2", 1'b0, 1'b0, 1'b0, 8'd0);
      exp_both(154, "idle_abort3", 1'b0, 1'b0, 1'b0, 8'd0);
      wait_cyc(150); key = 1'b0; abort = 1'b1;
      wait_cyc(151); abort = 1'b0;
      wait_cyc(158);
      for (int i = 0; i < 2; i++) chk_delta("idle_abort", i, 0, 0, 0);

      // Zero duration press is ignored.
      snap();
      wait_cyc(160);
      key = 1'b1; duration = 8'd0;
      exp_both(163, "zero_a", 1'b0, 1'b0, 1'b0, 8'd0);
      exp_both(165, "zero_b", 1'b0, 1'b0, 1'b0, 8'd0);
      wait_cyc(162); key = 1'b0;
      wait_cyc(172);
      for (int i = 0; i < 2; i++) chk_delta("zero", i, 0, 0, 0);

      // Reset between edges mid-run, then a normal window.
      wait_cyc(180);
      key = 1'b1; duration = 8'd3;
      exp_both(183, "rst_start", 1'b1, 1'b0, 1'b0, 8'd3);
      exp_both(187, "rst_tick",  1'b1, 1'b0, 1'b1, 8'd2);
      wait_cyc(182); key = 1'b0;
      wait_cyc(188);
      #2 rst_n = 1'b0;
      #1 chk_zero("reset_mid");
      exp_both(189, "rst_hold", 1'b0, 1'b0, 1'b0, 8'd0);
      wait_cyc(190);
      rst_n = 1'b1;
      wait_cyc(193);
      snap();
      wait_cyc(195);
      key = 1'b1; duration = 8'd3;
      exp_both(198, "post_start", 1'b1, 1'b0, 1'b0, 8'd3);
      exp_both(202, "post_tick1", 1'b1, 1'b0, 1'b1, 8'd2);
      exp_both(206, "post_tick2", 1'b1, 1'b0, 1'b1, 8'd1);
      exp_both(210, "post_done",  1'b0, 1'b1, 1'b1, 8'd0);
      exp_both(211, "post_idle",  1'b0, 1'b0, 1'b0, 8'd0);
      wait_cyc(214);
      key = 1'b0;
      for (int i = 0; i < 2; i++) chk_delta("post_reset", i, 12, 1, 3);

      wait_cyc(220);
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
